stream_mux_rr: RTL and testbench
================================

Name: stream_mux_rr

Overview:
- Parametrised, registered N-to-1 stream multiplexer; successor to the combinational 8:1 4-bit mux tree.
- Adds valid/ready handshakes per channel, a registered output stage, and two selection modes: fixed select via op, or round-robin arbitration.
- Sits between multiple producer blocks and one downstream consumer.
- Default parameters reproduce the 8-channel x 4-bit configuration.

Parameters:
- NUM_CH, 8, number of input channels; legal range 2..2**SEL_W.
- WIDTH, 4, data bits per channel.
- SEL_W, 3, width of op and out_ch; must be >= clog2(NUM_CH).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  NUM_CH*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  NUM_CH  per-channel valid.
- in_ready  output  NUM_CH  per-channel ready (combinational).
- mode  input  1  0 = fixed select by op; 1 = round-robin.
- op  input  SEL_W  channel select in fixed mode; ignored in round-robin mode.
- out_data  output  WIDTH  registered output data.
- out_ch  output  SEL_W  index of the channel that supplied out_data.
- out_valid  output  1  registered output valid.
- out_ready  input  1  downstream ready.

Behaviour:
- Reset (asynchronous assert, synchronous release): out_valid=0, out_data=0, out_ch=0, RR pointer ptr=0.
- Output register:
  - load = ~out_valid | out_ready.
  - An output beat transfers when out_valid & out_ready.
  - out_data, out_ch and out_valid hold while out_valid & ~out_ready.
- Grant (combinational, one-hot or zero):
  - Fixed mode: grant[op] = in_valid[op] when op < NUM_CH.
  - Fixed mode, op >= NUM_CH: no grant; all in_ready low.
  - Round-robin mode: search channels ptr, ptr+1, ... NUM_CH-1, 0, ... ptr-1; grant the first with in_valid=1.
- Handshake: in_ready[i] = load & grant[i]. At most one in_ready is high per cycle.
- Capture: when a grant exists and load=1, on the next edge:
  - out_data <= granted channel data; out_ch <= granted index; out_valid <= 1.
  - In round-robin mode, ptr <= (index+1) mod NUM_CH, wrapping from NUM_CH-1 to 0.
- No grant and load=1: out_valid <= 0 on the next edge; out_data and out_ch retain their last values.
- Latency: 1 cycle from input handshake to out_valid.
- Throughput: 1 beat/cycle when out_ready is held high (simultaneous drain and load allowed).
- ptr is updated only by round-robin grants. Fixed-mode grants leave ptr unchanged.
- mode and op are sampled every cycle with no state. A mode switch takes effect on the next grant; an already-registered output beat is unaffected.
- in_valid is not required to be sticky. If a producer drops valid before getting ready, nothing is captured.
- Reset mid-transfer drops any held output beat; no in_ready is asserted while rst=1.

Test Plan:
- Reset, then fixed mode with op=5, in_valid=8'hFF, channel i data=i+1, out_ready=1 -> in_ready=8'h20 every cycle; out_data=4'h6 and out_ch=5 from cycle 1 onward.
- Round-robin, in_valid=8'b1001_0010, out_ready=1 -> out_ch sequence 1,4,7,1,4,7; ptr wraps correctly.
- Round-robin, all valid, out_ready=0 for 3 cycles after the first capture -> out_data/out_ch held; in_ready=0 during the stall; next grant resumes at ptr=1 after ready returns.
- Fixed mode with op=3'd7 and NUM_CH=6 (SEL_W=3) -> in_ready=0 and out_valid falls to 0 after one cycle.
- Assert rst while out_valid=1 and out_ready=0 -> outputs immediately out_valid=0, out_data=0, out_ch=0; after release, round-robin grants start at channel 0.
- Switch mode 1->0 in the middle of a round-robin sequence with op=2 -> next capture is channel 2. Switching back to round-robin resumes from the unchanged ptr.

Source files
------------

// File: rtl/stream_mux_rr.sv
// Registered N-to-1 stream multiplexer with valid/ready handshakes.
// The input channel is chosen either by a fixed select (op) or by round-robin arbitration.
module stream_mux_rr #(
    parameter int NUM_CH = 8,
    parameter int WIDTH  = 4,
    parameter int SEL_W  = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    input  logic [NUM_CH-1:0]       in_valid,
    output logic [NUM_CH-1:0]       in_ready,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        op,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_ch,
    output logic                    out_valid,
    input  logic                    out_ready
);

    localparam logic [SEL_W:0]   NUM_CH_X = (SEL_W + 1)'(NUM_CH);
    localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(NUM_CH - 1);

    logic             load;
    logic             found;
    logic [SEL_W-1:0] gidx;
    logic [WIDTH-1:0] gdata;
    logic [SEL_W-1:0] ptr;
    logic [SEL_W:0]   cand;

    assign load = ~out_valid | out_ready;

    // Grant search: round-robin scans upward from ptr with wrap; fixed mode only honours op < NUM_CH.
    always_comb begin
        found = 1'b0;
        gidx  = '0;
        cand  = '0;
        if (mode) begin
            for (int k = 0; k < NUM_CH; k++) begin
                cand = {1'b0, ptr} + (SEL_W + 1)'(k);
                if (cand >= NUM_CH_X) begin
                    cand = cand - NUM_CH_X;
                end
                if (!found && in_valid[cand[SEL_W-1:0]]) begin
                    found = 1'b1;
                    gidx  = cand[SEL_W-1:0];
                end
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (op == SEL_W'(i) && in_valid[i]) begin
                    found = 1'b1;
                    gidx  = SEL_W'(i);
                end
            end
        end
    end

    always_comb begin
        gdata    = '0;
        in_ready = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (gidx == SEL_W'(i)) begin
                gdata       = in_data[i*WIDTH +: WIDTH];
                in_ready[i] = ~rst & load & found;
            end
        end
    end

    // Output stage: loads whenever empty or draining; ptr moves only on round-robin grants.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            ptr       <= '0;
        end else if (load) begin
            out_valid <= found;
            if (found) begin
                out_data <= gdata;
                out_ch   <= gidx;
                if (mode) begin
                    ptr <= (gidx == LAST_CH) ? '0 : gidx + SEL_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Scoreboard bench for stream_mux_rr: stimulus pushes hand-computed beats,
// a negedge monitor pops and compares every transferred output beat.
module tb_stream_mux_rr;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_data;
    logic [7:0]  in_valid;
    logic [7:0]  in_ready;
    logic        mode;
    logic [2:0]  op;
    logic [3:0]  out_data;
    logic [2:0]  out_ch;
    logic        out_valid;
    logic        out_ready;

    logic [23:0] in_data6;
    logic [5:0]  in_valid6;
    logic [5:0]  in_ready6;
    logic [3:0]  out_data6;
    logic [2:0]  out_ch6;
    logic        out_valid6;

    int checks = 0;
    int errors = 0;
    logic [6:0] exp_q[$];

    always #5 clk = ~clk;

    stream_mux_rr dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .mode(mode), .op(op), .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    stream_mux_rr #(.NUM_CH(6), .WIDTH(4), .SEL_W(3)) dut6 (
        .clk(clk), .rst(rst), .in_data(in_data6), .in_valid(in_valid6), .in_ready(in_ready6),
        .mode(mode), .op(op), .out_data(out_data6), .out_ch(out_ch6), .out_valid(out_valid6),
        .out_ready(out_ready)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected beat is {channel, data}; channel i carries data i+1.
    task automatic expect_beat(input int ch);
        exp_q.push_back({3'(ch), 4'(ch + 1)});
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_beat: got ch=%0d data=%0h with empty queue", out_ch, out_data);
            end else begin
                logic [6:0] e;
                e = exp_q.pop_front();
                if ({out_ch, out_data} !== e) begin
                    errors++;
                    $display("FAIL beat: got ch=%0d data=%0h expected ch=%0d data=%0h",
                             out_ch, out_data, e[6:4], e[3:0]);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 8; i++) in_data[i*4 +: 4] = 4'(i + 1);
        for (int i = 0; i < 6; i++) in_data6[i*4 +: 4] = 4'(i + 1);
        rst = 1'b1; in_valid = '0; in_valid6 = '0; mode = 1'b0; op = '0; out_ready = 1'b1;
        #1;
        check("reset_valid", 32'(out_valid), 0);
        check("reset_data", 32'(out_data), 0);
        check("reset_ch", 32'(out_ch), 0);
        step(); step();
        rst = 1'b0;

        // Fixed select op=5
        mode = 1'b0; op = 3'd5; in_valid = 8'hFF;
        for (int c = 0; c < 4; c++) begin
            #1 check("fixed_ready", 32'(in_ready), 32'h20);
            expect_beat(5);
            step();
            check("fixed_data", 32'(out_data), 32'h6);
        end
        in_valid = '0; step();

        // Round-robin over sparse valids: 1,4,7,1,4,7
        mode = 1'b1; in_valid = 8'b1001_0010;
        for (int c = 0; c < 6; c++) begin
            int ch;
            ch = (c % 3 == 0) ? 1 : (c % 3 == 1) ? 4 : 7;
            #1 check("rr_ready", 32'(in_ready), 32'(1 << ch));
            expect_beat(ch);
            step();
        end
        in_valid = '0; step();

        // Round-robin with a three-cycle downstream stall
        in_valid = 8'hFF;
        #1 check("stall_first_ready", 32'(in_ready), 32'h01);
        expect_beat(0);
        step();
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1 check("stall_ready", 32'(in_ready), 0);
            check("stall_hold", {out_valid, out_ch, out_data}, {1'b1, 3'd0, 4'h1});
            step();
        end
        out_ready = 1'b1;
        #1 check("stall_resume_ready", 32'(in_ready), 32'h02);
        expect_beat(1);
        step();
        in_valid = '0; step();

        // Mode switch mid-sequence: rr 2,3 then fixed op=2 then rr resumes at 4
        in_valid = 8'hFF;
        #1 check("sw_rr_a", 32'(in_ready), 32'h04);
        expect_beat(2); step();
        #1 check("sw_rr_b", 32'(in_ready), 32'h08);
        expect_beat(3); step();
        mode = 1'b0; op = 3'd2;
        #1 check("sw_fixed", 32'(in_ready), 32'h04);
        expect_beat(2); step();
        mode = 1'b1;
        #1 check("sw_rr_resume", 32'(in_ready), 32'h10);
        expect_beat(4); step();
        in_valid = '0; step();

        // Reset while a beat is held under backpressure; the beat is dropped
        in_valid = 8'hFF; out_ready = 1'b0;
        #1 check("rst_pre_ready", 32'(in_ready), 32'h20);
        step();
        check("rst_pre_hold", {out_valid, out_ch, out_data}, {1'b1, 3'd5, 4'h6});
        rst = 1'b1;
        #1 check("rst_async_out", {out_valid, out_ch, out_data}, 0);
        check("rst_in_ready", 32'(in_ready), 0);
        step();
        rst = 1'b0; out_ready = 1'b1;
        #1 check("rst_rr_restart", 32'(in_ready), 32'h01);
        expect_beat(0); step();
        in_valid = '0; step();

        // Six-channel instance: op=7 is out of range
        mode = 1'b0; op = 3'd2; in_valid6 = 6'h3F;
        #1 check("ch6_fixed_ready", 32'(in_ready6), 32'h04);
        step();
        check("ch6_captured", {out_valid6, out_ch6, out_data6}, {1'b1, 3'd2, 4'h3});
        op = 3'd7;
        #1 check("ch6_oor_ready", 32'(in_ready6), 0);
        step();
        check("ch6_oor_valid", 32'(out_valid6), 0);
        check("ch6_oor_retain", {out_ch6, out_data6}, {3'd2, 4'h3});
        in_valid6 = '0;

        step(); step();
        check("queue_drained", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
